vram_access_arbiter: RTL and testbench
======================================

Name: vram_access_arbiter

Overview:
- Shares the single LCD RAM (VRAM) port between three requesters: PPU fetch, DMA (general/HBlank DMA), and CPU via the memory router.
- Serializes requests, applies a fixed priority with a CPU anti-starvation override, and enforces the PPU mode-3 CPU lockout.
- Sits between `memory_router` / `dma_controller` / PPU and `lcdram`; it owns the LCD RAM addr/data/strobe pins.

Parameters:
- ADDR_W, 16, width of every address port.
- RD_LAT, 1, memory cycles from the RE_L strobe to valid I_MEM_RDATA (legal range 1..3).
- STARVE_MAX, 8, number of consecutive lost arbitrations after which a pending CPU request wins.

Ports:
- I_CLK  in  1  system clock; every register in the block is on this clock.
- I_SYNC_RESET_L  in  1  synchronous, active-low reset.
- I_LCD_EN  in  1  LCDC bit 7.
- I_PPU_MODE  in  2  PPU mode: 0 hblank, 1 vblank, 2 OAM search, 3 transfer.
- I_PPU_REQ  in  1  PPU read request; held until the grant.
- I_PPU_ADDR  in  ADDR_W  PPU read address.
- O_PPU_GNT  out  1  one-cycle pulse: PPU request accepted.
- O_PPU_RDATA  out  8  read data returned to the PPU.
- O_PPU_RVALID  out  1  one-cycle pulse qualifying O_PPU_RDATA.
- I_DMA_REQ, I_DMA_WE, I_DMA_ADDR, I_DMA_WDATA  in  1,1,ADDR_W,8  DMA request, held until the grant.
- O_DMA_GNT, O_DMA_RDATA, O_DMA_RVALID  out  1,8,1  as for the PPU.
- I_CPU_REQ, I_CPU_WE, I_CPU_ADDR, I_CPU_WDATA  in  1,1,ADDR_W,8  CPU request, held until the grant.
- O_CPU_GNT, O_CPU_RDATA, O_CPU_RVALID  out  1,8,1  as for the PPU.
- O_CPU_BLOCKED  out  1  one-cycle pulse: a CPU access was swallowed by the mode-3 lockout.
- O_MEM_ADDR  out  ADDR_W  address to LCD RAM.
- O_MEM_WDATA  out  8  write data to LCD RAM.
- O_MEM_WE_L  out  1  active-low write strobe.
- O_MEM_RE_L  out  1  active-low read strobe.
- I_MEM_RDATA  in  8  LCD RAM read data.

Behaviour:
- Reset values (on I_SYNC_RESET_L = 0 at a rising edge):
  - All GNT, RVALID and BLOCKED outputs = 0.
  - All RDATA = 8'h00.
  - O_MEM_WE_L = O_MEM_RE_L = 1; O_MEM_ADDR = 0; O_MEM_WDATA = 0.
  - Starvation counter = 0; FSM in IDLE.
- Reset during an operation: any outstanding read is discarded (no RVALID) and no strobe is asserted on the following cycle.
- Lockout:
  - lock = I_LCD_EN && I_PPU_MODE == 3.
  - While lock is true, CPU requests never reach memory.
- FSM states: IDLE, ISSUE, RD_WAIT, RETURN.
- IDLE, arbitration runs each cycle:
  - Winner order: CPU if starve_cnt == STARVE_MAX and !lock; else PPU; else DMA; else CPU if !lock.
  - Winner: its GNT pulses this cycle; addr/we/wdata are latched; next state = ISSUE.
  - Locked CPU request: O_CPU_GNT and O_CPU_BLOCKED pulse, regardless of other requesters.
    - Read: O_CPU_RDATA = 8'hFF with O_CPU_RVALID on the next cycle.
    - Write: dropped.
    - FSM stays in IDLE, so PPU/DMA arbitration proceeds in the same cycle.
- ISSUE: drive the latched address; assert exactly one strobe (WE_L = 0 or RE_L = 0) for one cycle.
  - Write: next state IDLE.
  - Read: next state RD_WAIT.
- RD_WAIT: count RD_LAT-1 cycles (0 cycles when RD_LAT = 1), then sample I_MEM_RDATA into the winner's RDATA; next state RETURN.
- RETURN: winner's RVALID pulses for one cycle; next state IDLE.
- Latency:
  - Write: grant to strobe = 1 cycle.
  - Read: grant to RVALID = RD_LAT + 2 cycles.
  - One access outstanding at a time.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when the CPU is requesting, !lock, and another requester wins.
  - Clears when the CPU wins, or when the CPU is not requesting.
  - Holds during lock.
- PPU with I_LCD_EN = 0: PPU requests are still served (no filtering).
- Requests from non-granted requesters may change freely; only the granted request is latched.
- RDATA outputs hold their last value between RVALID pulses.

Decomposition:
- Shared package `vram_arb_pkg`:
  - PPU mode constants (MODE_HBLANK, MODE_VBLANK, MODE_OAM, MODE_XFER).
  - Requester IDs (REQ_PPU = 0, REQ_DMA = 1, REQ_CPU = 2).
  - OPEN_BUS = 8'hFF.
  - FSM state encoding.
- One sub-module, `vram_arb_pick`: combinational priority plus registered starvation counter.
  - Inputs: reqs, lock, busy.
  - Outputs: winner one-hot, cpu_blocked.
- The top holds the FSM, request latches and the read-latency counter.

Test Plan:
- Reset mid-read: CPU read of 0x8000 granted, reset asserted during RD_WAIT → no CPU_RVALID, all strobes high, outputs at reset values.
- Single accesses, RD_LAT = 1, mode 1:
  - CPU write 0x8010 = 0x5A → WE_L low exactly 1 cycle after GNT.
  - Later CPU read of 0x8010, memory returns 0x5A → CPU_RVALID 3 cycles after GNT with RDATA = 0x5A.
- Simultaneous requests: PPU 0x9800, DMA write 0x8100, and CPU read all raised together in mode 0 → grants in order PPU, DMA, CPU with no overlapping strobes.
- Starvation: PPU and DMA requesting continuously alongside the CPU, mode 0, STARVE_MAX = 8 → CPU granted on the 9th arbitration; counter then reads 0.
- Lockout:
  - LCD_EN = 1, mode 3, CPU read 0x8000 → GNT + BLOCKED same cycle; RVALID next cycle with 0xFF; MEM strobes never asserted.
  - CPU write 0x8000 = 0x12 in the same conditions → memory unchanged.
- Lockout released: same CPU read with LCD_EN = 0 in mode 3 → normal memory read.
- RD_LAT = 3 build: PPU read → RVALID 5 cycles after GNT with the memory value sampled 3 cycles after RE_L.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared constants and types for the VRAM access arbiter.
package vram_arb_pkg;

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_XFER   = 2'd3;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_PPU = 2'd0;
    localparam req_id_t REQ_DMA = 2'd1;
    localparam req_id_t REQ_CPU = 2'd2;
    localparam int      NUM_REQ = 3;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RETURN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/vram_arb_pick.sv
// Fixed-priority winner selection with CPU anti-starvation override and mode-3 CPU lockout.
module vram_arb_pick
    import vram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic               I_CLK,
    input  logic               I_SYNC_RESET_L,
    input  logic [NUM_REQ-1:0] I_REQS,
    input  logic               I_LOCK,
    input  logic               I_BUSY,
    output logic [NUM_REQ-1:0] O_WINNER,
    output logic               O_CPU_BLOCKED
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_cpu_starved;

    assign w_cpu_starved = (r_starve_cnt == CNT_W'(STARVE_MAX)) && !I_LOCK;

    always_comb begin
        O_WINNER      = '0;
        O_CPU_BLOCKED = 1'b0;
        if (!I_BUSY) begin
            O_CPU_BLOCKED = I_REQS[REQ_CPU] && I_LOCK;
            if (I_REQS[REQ_CPU] && w_cpu_starved) begin
                O_WINNER[REQ_CPU] = 1'b1;
            end else if (I_REQS[REQ_PPU]) begin
                O_WINNER[REQ_PPU] = 1'b1;
            end else if (I_REQS[REQ_DMA]) begin
                O_WINNER[REQ_DMA] = 1'b1;
            end else if (I_REQS[REQ_CPU] && !I_LOCK) begin
                O_WINNER[REQ_CPU] = 1'b1;
            end
        end
    end

    // Only counts arbitrations the CPU actually lost; a locked CPU is not starving.
    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RESET_L) begin
            r_starve_cnt <= '0;
        end else if (I_LOCK) begin
            r_starve_cnt <= r_starve_cnt;
        end else if (!I_REQS[REQ_CPU] || O_WINNER[REQ_CPU]) begin
            r_starve_cnt <= '0;
        end else if (|O_WINNER && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vram_access_arbiter.sv
// Owns the LCD RAM port and serialises PPU, DMA and CPU accesses, one outstanding at a time.
//   state   | meaning
//   IDLE    | arbitrate; a grant latches the winner's request
//   ISSUE   | drive latched address with exactly one strobe for one cycle
//   RD_WAIT | wait out the read latency, capture I_MEM_RDATA for the owner
//   RETURN  | pulse the owner's RVALID
module vram_access_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              I_CLK,
    input  logic              I_SYNC_RESET_L,
    input  logic              I_LCD_EN,
    input  logic [1:0]        I_PPU_MODE,
    input  logic              I_PPU_REQ,
    input  logic [ADDR_W-1:0] I_PPU_ADDR,
    output logic              O_PPU_GNT,
    output logic [7:0]        O_PPU_RDATA,
    output logic              O_PPU_RVALID,
    input  logic              I_DMA_REQ,
    input  logic              I_DMA_WE,
    input  logic [ADDR_W-1:0] I_DMA_ADDR,
    input  logic [7:0]        I_DMA_WDATA,
    output logic              O_DMA_GNT,
    output logic [7:0]        O_DMA_RDATA,
    output logic              O_DMA_RVALID,
    input  logic              I_CPU_REQ,
    input  logic              I_CPU_WE,
    input  logic [ADDR_W-1:0] I_CPU_ADDR,
    input  logic [7:0]        I_CPU_WDATA,
    output logic              O_CPU_GNT,
    output logic [7:0]        O_CPU_RDATA,
    output logic              O_CPU_RVALID,
    output logic              O_CPU_BLOCKED,
    output logic [ADDR_W-1:0] O_MEM_ADDR,
    output logic [7:0]        O_MEM_WDATA,
    output logic              O_MEM_WE_L,
    output logic              O_MEM_RE_L,
    input  logic [7:0]        I_MEM_RDATA
);

    localparam int LAT_W = 2;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    req_id_t             r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_blk_rvalid;
    logic [7:0]          r_ppu_rdata;
    logic [7:0]          r_dma_rdata;
    logic [7:0]          r_cpu_rdata;

    logic [NUM_REQ-1:0]  w_reqs;
    logic [NUM_REQ-1:0]  w_win;
    logic                w_lock;
    logic                w_busy;
    logic                w_cpu_blocked;
    logic                w_blk_read;
    logic                w_capture;
    logic                w_ret;
    req_id_t             w_win_id;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [7:0]          w_win_wdata;

    assign w_reqs[REQ_PPU] = I_PPU_REQ;
    assign w_reqs[REQ_DMA] = I_DMA_REQ;
    assign w_reqs[REQ_CPU] = I_CPU_REQ;

    assign w_lock = I_LCD_EN && (I_PPU_MODE == MODE_XFER);
    // Holding reset counts as busy so no grant can leak out while in reset.
    assign w_busy = (r_state != ST_IDLE) || !I_SYNC_RESET_L;

    vram_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .I_CLK          (I_CLK),
        .I_SYNC_RESET_L (I_SYNC_RESET_L),
        .I_REQS         (w_reqs),
        .I_LOCK         (w_lock),
        .I_BUSY         (w_busy),
        .O_WINNER       (w_win),
        .O_CPU_BLOCKED  (w_cpu_blocked)
    );

    assign w_blk_read = w_cpu_blocked && !I_CPU_WE;
    assign w_capture  = (r_state == ST_RD_WAIT) && (r_lat_cnt == '0);
    assign w_ret      = (r_state == ST_RETURN);

    always_comb begin
        w_win_id    = REQ_PPU;
        w_win_we    = 1'b0;
        w_win_addr  = I_PPU_ADDR;
        w_win_wdata = '0;
        if (w_win[REQ_DMA]) begin
            w_win_id    = REQ_DMA;
            w_win_we    = I_DMA_WE;
            w_win_addr  = I_DMA_ADDR;
            w_win_wdata = I_DMA_WDATA;
        end else if (w_win[REQ_CPU]) begin
            w_win_id    = REQ_CPU;
            w_win_we    = I_CPU_WE;
            w_win_addr  = I_CPU_ADDR;
            w_win_wdata = I_CPU_WDATA;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (|w_win) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = r_we ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT: if (r_lat_cnt == '0) w_state_nxt = ST_RETURN;
            ST_RETURN:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RESET_L) begin
            r_state      <= ST_IDLE;
            r_owner      <= REQ_PPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_lat_cnt    <= '0;
            r_blk_rvalid <= 1'b0;
            r_ppu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_blk_rvalid <= w_blk_read;
            if (|w_win) begin
                r_owner <= w_win_id;
                r_we    <= w_win_we;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= LAT_W'(RD_LAT - 1);
            end else if ((r_state == ST_RD_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_blk_read) begin
                r_cpu_rdata <= OPEN_BUS;
            end else if (w_capture) begin
                if (r_owner == REQ_PPU) begin
                    r_ppu_rdata <= I_MEM_RDATA;
                end else if (r_owner == REQ_DMA) begin
                    r_dma_rdata <= I_MEM_RDATA;
                end else begin
                    r_cpu_rdata <= I_MEM_RDATA;
                end
            end
        end
    end

    assign O_PPU_GNT     = w_win[REQ_PPU];
    assign O_DMA_GNT     = w_win[REQ_DMA];
    assign O_CPU_GNT     = w_win[REQ_CPU] || w_cpu_blocked;
    assign O_CPU_BLOCKED = w_cpu_blocked;

    assign O_PPU_RVALID  = w_ret && (r_owner == REQ_PPU);
    assign O_DMA_RVALID  = w_ret && (r_owner == REQ_DMA);
    assign O_CPU_RVALID  = (w_ret && (r_owner == REQ_CPU)) || r_blk_rvalid;

    assign O_PPU_RDATA   = r_ppu_rdata;
    assign O_DMA_RDATA   = r_dma_rdata;
    assign O_CPU_RDATA   = r_cpu_rdata;

    assign O_MEM_ADDR    = r_addr;
    assign O_MEM_WDATA   = r_wdata;
    assign O_MEM_WE_L    = !((r_state == ST_ISSUE) && r_we);
    assign O_MEM_RE_L    = !((r_state == ST_ISSUE) && !r_we);

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Self-checking bench for vram_access_arbiter: grant table plus directed multi-cycle sequences.
module tb_vram_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l, lcd_en;
    logic [1:0]  mode;
    logic        ppu_req, dma_req, dma_we, cpu_req, cpu_we;
    logic [15:0] ppu_addr, dma_addr, cpu_addr;
    logic [7:0]  dma_wdata, cpu_wdata;

    logic        ppu_gnt, ppu_rvalid, dma_gnt, dma_rvalid, cpu_gnt, cpu_rvalid, cpu_blocked;
    logic [7:0]  ppu_rdata, dma_rdata, cpu_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_we_l, mem_re_l;

    logic        t3_ppu_gnt, t3_ppu_rvalid, t3_dma_gnt, t3_dma_rvalid, t3_cpu_gnt, t3_cpu_rvalid, t3_cpu_blocked;
    logic [7:0]  t3_ppu_rdata, t3_dma_rdata, t3_cpu_rdata, t3_mem_wdata, t3_mem_rdata;
    logic [15:0] t3_mem_addr;
    logic        t3_mem_we_l, t3_mem_re_l;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign t3_mem_rdata = cyc[7:0];

    vram_access_arbiter #(.ADDR_W(16), .RD_LAT(1), .STARVE_MAX(8)) dut (
        .I_CLK(clk), .I_SYNC_RESET_L(rst_l), .I_LCD_EN(lcd_en), .I_PPU_MODE(mode),
        .I_PPU_REQ(ppu_req), .I_PPU_ADDR(ppu_addr),
        .O_PPU_GNT(ppu_gnt), .O_PPU_RDATA(ppu_rdata), .O_PPU_RVALID(ppu_rvalid),
        .I_DMA_REQ(dma_req), .I_DMA_WE(dma_we), .I_DMA_ADDR(dma_addr), .I_DMA_WDATA(dma_wdata),
        .O_DMA_GNT(dma_gnt), .O_DMA_RDATA(dma_rdata), .O_DMA_RVALID(dma_rvalid),
        .I_CPU_REQ(cpu_req), .I_CPU_WE(cpu_we), .I_CPU_ADDR(cpu_addr), .I_CPU_WDATA(cpu_wdata),
        .O_CPU_GNT(cpu_gnt), .O_CPU_RDATA(cpu_rdata), .O_CPU_RVALID(cpu_rvalid),
        .O_CPU_BLOCKED(cpu_blocked),
        .O_MEM_ADDR(mem_addr), .O_MEM_WDATA(mem_wdata), .O_MEM_WE_L(mem_we_l),
        .O_MEM_RE_L(mem_re_l), .I_MEM_RDATA(mem_rdata)
    );

    vram_access_arbiter #(.ADDR_W(16), .RD_LAT(3), .STARVE_MAX(8)) dut3 (
        .I_CLK(clk), .I_SYNC_RESET_L(rst_l), .I_LCD_EN(lcd_en), .I_PPU_MODE(mode),
        .I_PPU_REQ(ppu_req), .I_PPU_ADDR(ppu_addr),
        .O_PPU_GNT(t3_ppu_gnt), .O_PPU_RDATA(t3_ppu_rdata), .O_PPU_RVALID(t3_ppu_rvalid),
        .I_DMA_REQ(dma_req), .I_DMA_WE(dma_we), .I_DMA_ADDR(dma_addr), .I_DMA_WDATA(dma_wdata),
        .O_DMA_GNT(t3_dma_gnt), .O_DMA_RDATA(t3_dma_rdata), .O_DMA_RVALID(t3_dma_rvalid),
        .I_CPU_REQ(cpu_req), .I_CPU_WE(cpu_we), .I_CPU_ADDR(cpu_addr), .I_CPU_WDATA(cpu_wdata),
        .O_CPU_GNT(t3_cpu_gnt), .O_CPU_RDATA(t3_cpu_rdata), .O_CPU_RVALID(t3_cpu_rvalid),
        .O_CPU_BLOCKED(t3_cpu_blocked),
        .O_MEM_ADDR(t3_mem_addr), .O_MEM_WDATA(t3_mem_wdata), .O_MEM_WE_L(t3_mem_we_l),
        .O_MEM_RE_L(t3_mem_re_l), .I_MEM_RDATA(t3_mem_rdata)
    );

    // VRAM model: unwritten locations read back a fixed address hash, 1-cycle read latency.
    logic [7:0] vmem [int];

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    function automatic logic [7:0] peek(input logic [15:0] a);
        if (vmem.exists(int'(a))) return vmem[int'(a)];
        return dflt(a);
    endfunction

    always @(posedge clk) begin
        if (!mem_we_l) vmem[int'(mem_addr)] = mem_wdata;
        if (!mem_re_l) mem_rdata <= peek(mem_addr);
    end

    // Event log sampled mid-cycle.
    int         n_gnt [3] = '{0, 0, 0};
    int         gnt_cyc [3] = '{0, 0, 0};
    int         rv_cnt [3] = '{0, 0, 0};
    int         rv_cyc [3] = '{0, 0, 0};
    logic [7:0] rv_data [3] = '{8'h0, 8'h0, 8'h0};
    int         order [$];
    int         blk_cyc = 0, n_blk = 0, we_cyc = 0, re_cyc = 0, n_we = 0, n_re = 0, n_overlap = 0;
    int         t3_gnt_cyc = 0, t3_re_cyc = 0, t3_rv_cyc = 0, t3_rv_n = 0;
    logic [7:0] t3_rv_data = 8'h0;

    always @(negedge clk) begin
        if (ppu_gnt) begin n_gnt[0]++; gnt_cyc[0] = cyc; order.push_back(0); end
        if (dma_gnt) begin n_gnt[1]++; gnt_cyc[1] = cyc; order.push_back(1); end
        if (cpu_gnt) begin n_gnt[2]++; gnt_cyc[2] = cyc; order.push_back(2); end
        if (cpu_blocked) begin n_blk++; blk_cyc = cyc; end
        if (!mem_we_l) begin n_we++; we_cyc = cyc; end
        if (!mem_re_l) begin n_re++; re_cyc = cyc; end
        if (!mem_we_l && !mem_re_l) n_overlap++;
        if (ppu_rvalid) begin rv_cnt[0]++; rv_cyc[0] = cyc; rv_data[0] = ppu_rdata; end
        if (dma_rvalid) begin rv_cnt[1]++; rv_cyc[1] = cyc; rv_data[1] = dma_rdata; end
        if (cpu_rvalid) begin rv_cnt[2]++; rv_cyc[2] = cyc; rv_data[2] = cpu_rdata; end
        if (t3_ppu_gnt) t3_gnt_cyc = cyc;
        if (!t3_mem_re_l) t3_re_cyc = cyc;
        if (t3_ppu_rvalid) begin t3_rv_n++; t3_rv_cyc = cyc; t3_rv_data = t3_ppu_rdata; end
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Requesters drop their request the cycle after a grant unless held.
    logic gp, gd, gc, hold;

    task automatic tick();
        @(negedge clk);
        gp = ppu_gnt; gd = dma_gnt; gc = cpu_gnt;
        @(posedge clk);
        #1;
        if (gp && !hold) ppu_req = 1'b0;
        if (gd && !hold) dma_req = 1'b0;
        if (gc) cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        ppu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
        tick(); tick();
        rst_l = 1'b1;
    endtask

    task automatic wait_gnt(input int r, input int budget, output int g);
        int n0 = n_gnt[r];
        int k = 0;
        while (n_gnt[r] == n0 && k < budget) begin tick(); k++; end
        check($sformatf("gnt_seen_r%0d", r), int'(n_gnt[r] != n0), 1);
        g = gnt_cyc[r];
    endtask

    typedef struct packed {
        logic       lcd;
        logic [1:0] mode;
        logic       ppu, dma, cpu, cpu_we;
        logic [3:0] exp_gdcb;
    } vec_t;

    vec_t vecs [11];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int g, base, k, n0, nb0, nre0, nwe0, rv0, ov0;

        vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010};
        vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[3]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000};
        vecs[4]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011};
        vecs[5]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011};
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};

        hold = 1'b0;
        rst_l = 1'b0; lcd_en = 1'b1; mode = 2'd1;
        ppu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        ppu_addr = 16'h0; dma_addr = 16'h0; cpu_addr = 16'h0; dma_wdata = 8'h0; cpu_wdata = 8'h0;

        // Reset state, with a live CPU request that must not be granted.
        cpu_req = 1'b1; cpu_addr = 16'h8000;
        tick(); tick();
        #1;
        check("rst_gnt_blk", int'({ppu_gnt, dma_gnt, cpu_gnt, cpu_blocked}), 0);
        check("rst_rvalid", int'({ppu_rvalid, dma_rvalid, cpu_rvalid}), 0);
        check("rst_rdata", int'({ppu_rdata, dma_rdata, cpu_rdata}), 0);
        check("rst_strobes", int'({mem_we_l, mem_re_l}), 3);
        check("rst_addr_wdata", int'({mem_addr, mem_wdata}), 0);
        cpu_req = 1'b0;
        rst_l = 1'b1;
        tick();

        // Grant table, each vector from a fresh reset.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            lcd_en = vecs[i].lcd; mode = vecs[i].mode; cpu_we = vecs[i].cpu_we;
            dma_we = 1'b0; cpu_addr = 16'h8020; ppu_addr = 16'h9000; dma_addr = 16'h8800;
            ppu_req = vecs[i].ppu; dma_req = vecs[i].dma; cpu_req = vecs[i].cpu;
            #2;
            check($sformatf("vec%0d_gnt_pdcb", i), int'({ppu_gnt, dma_gnt, cpu_gnt, cpu_blocked}),
                  int'(vecs[i].exp_gdcb));
        end
        do_reset();

        // Reset during RD_WAIT discards the read.
        lcd_en = 1'b1; mode = 2'd1; cpu_we = 1'b0; cpu_addr = 16'h8000;
        nre0 = n_re; rv0 = rv_cnt[2];
        cpu_req = 1'b1;
        wait_gnt(2, 10, g);
        tick();
        rst_l = 1'b0;
        tick();
        #1;
        check("midrst_strobes", int'({mem_we_l, mem_re_l}), 3);
        check("midrst_addr", int'(mem_addr), 0);
        check("midrst_rvalid_rdata", int'({cpu_rvalid, cpu_rdata}), 0);
        tick();
        rst_l = 1'b1;
        repeat (5) tick();
        check("midrst_no_rvalid", rv_cnt[2] - rv0, 0);
        check("midrst_one_re", n_re - nre0, 1);

        // CPU write then read back, RD_LAT = 1.
        cpu_we = 1'b1; cpu_addr = 16'h8010; cpu_wdata = 8'h5A; nwe0 = n_we;
        cpu_req = 1'b1;
        wait_gnt(2, 10, g);
        repeat (4) tick();
        check("wr_gnt_to_we", we_cyc - g, 1);
        check("wr_we_count", n_we - nwe0, 1);
        check("wr_mem", int'(peek(16'h8010)), 'h5A);
        cpu_we = 1'b0; rv0 = rv_cnt[2];
        cpu_req = 1'b1;
        wait_gnt(2, 10, g);
        repeat (5) tick();
        check("rd_gnt_to_rvalid", rv_cyc[2] - g, 3);
        check("rd_data", int'(rv_data[2]), 'h5A);
        check("rd_rvalid_count", rv_cnt[2] - rv0, 1);

        // Simultaneous PPU read, DMA write, CPU read in hblank.
        mode = 2'd0; ppu_addr = 16'h9800; dma_we = 1'b1; dma_addr = 16'h8100; dma_wdata = 8'h33;
        cpu_we = 1'b0; cpu_addr = 16'h8010;
        base = order.size(); ov0 = n_overlap;
        ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1;
        k = 0;
        while (order.size() < base + 3 && k < 60) begin tick(); k++; end
        check("sim_grant_count", order.size() - base, 3);
        for (int j = 0; j < 3; j++)
            check($sformatf("sim_order%0d", j), (order.size() > base + j) ? order[base + j] : -1, j);
        check("sim_ppu_to_dma", gnt_cyc[1] - gnt_cyc[0], 4);
        check("sim_dma_to_cpu", gnt_cyc[2] - gnt_cyc[1], 2);
        repeat (6) tick();
        check("sim_ppu_data", int'(rv_data[0]), int'(dflt(16'h9800)));
        check("sim_dma_mem", int'(peek(16'h8100)), 'h33);
        check("sim_cpu_data", int'(rv_data[2]), 'h5A);
        check("sim_no_overlap", n_overlap - ov0, 0);

        // Starvation: PPU and DMA held, CPU must win the 9th arbitration.
        hold = 1'b1;
        base = order.size(); n0 = n_gnt[2];
        ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1;
        k = 0;
        while (n_gnt[2] == n0 && k < 200) begin tick(); k++; end
        check("starve_cpu_won", n_gnt[2] - n0, 1);
        check("starve_position", order.size() - base, 9);
        check("starve_ppu_wins", n_gnt[0] - (order.size() > base ? 0 : 0) >= 0 ? ((order.size() > base + 7) ? order[base + 7] : -1) : -1, 0);
        check("starve_cnt_cleared", int'(dut.u_pick.r_starve_cnt), 0);
        hold = 1'b0; ppu_req = 1'b0; dma_req = 1'b0;
        repeat (8) tick();

        // Mode-3 lockout: read returns open bus, write is dropped, no strobes.
        lcd_en = 1'b1; mode = 2'd3; cpu_we = 1'b0; cpu_addr = 16'h8000;
        nre0 = n_re; nwe0 = n_we; rv0 = rv_cnt[2]; nb0 = n_blk;
        cpu_req = 1'b1;
        wait_gnt(2, 10, g);
        tick(); tick();
        check("lock_rd_blk_same_cycle", blk_cyc, g);
        check("lock_rd_blk_count", n_blk - nb0, 1);
        check("lock_rd_rvalid_next", rv_cyc[2] - g, 1);
        check("lock_rd_data", int'(rv_data[2]), 'hFF);
        check("lock_rd_rvalid_count", rv_cnt[2] - rv0, 1);
        cpu_we = 1'b1; cpu_wdata = 8'h12; rv0 = rv_cnt[2];
        cpu_req = 1'b1;
        wait_gnt(2, 10, g);
        repeat (3) tick();
        check("lock_wr_blk_same_cycle", blk_cyc, g);
        check("lock_wr_mem_unchanged", int'(peek(16'h8000)), int'(dflt(16'h8000)));
        check("lock_wr_no_rvalid", rv_cnt[2] - rv0, 0);
        check("lock_no_strobes", (n_we - nwe0) + (n_re - nre0), 0);

        // Lock released by LCD off in mode 3.
        lcd_en = 1'b0; cpu_we = 1'b0; nb0 = n_blk; nre0 = n_re;
        cpu_req = 1'b1;
        wait_gnt(2, 10, g);
        repeat (5) tick();
        check("unlock_latency", rv_cyc[2] - g, 3);
        check("unlock_data", int'(rv_data[2]), int'(dflt(16'h8000)));
        check("unlock_no_blk", n_blk - nb0, 0);
        check("unlock_one_re", n_re - nre0, 1);

        // RD_LAT = 3 instance: PPU read.
        do_reset();
        lcd_en = 1'b1; mode = 2'd1; ppu_addr = 16'h9800; n0 = t3_rv_n;
        ppu_req = 1'b1;
        wait_gnt(0, 10, g);
        repeat (8) tick();
        check("lat3_gnt_cycle", t3_gnt_cyc, g);
        check("lat3_gnt_to_re", t3_re_cyc - t3_gnt_cyc, 1);
        check("lat3_gnt_to_rvalid", t3_rv_cyc - t3_gnt_cyc, 5);
        check("lat3_sample_point", int'(t3_rv_data), (t3_re_cyc + 3) & 255);
        check("lat3_rvalid_count", t3_rv_n - n0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
